csr_regs: RTL and testbench

Machine-mode CSR register file and trap sequencer. Holds mscratch, mstatus, mcause, mtvec and mepc, and executes CSRRW/CSRRS/CSRRC writes. Sequences trap entry and `mret`, redirecting fetch through a valid/ready handshake. Sits directly upstream of the CSR read decoder: it drives the `csr_out` array the decoder selects from, and it receives the decoder's `csr_read` value back as the old value for read-modify-write.

---
 rtl/csr_regs_if.sv | 61 ++++++
 rtl/csr_regs.sv | 250 +++++++++++++++++++++++++
 tb/tb_csr_regs.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_regs_if.sv
// -----------------------------------------------------------------------------
// csr_regs_if
//   Bus bundle between the core pipeline and the machine-mode CSR block.
//   Carries the CSR instruction write channel, the read-back value from the
//   CSR read decoder, the illegal-access flag, and the fetch-redirect
//   valid/ready handshake.
//
//   Signals:
//     csr_we         CSR instruction write request this cycle
//     csr_op         01 RW, 10 RS, 11 RC, 00 no-op
//     csr_addr       12-bit CSR address
//     csr_wdata      rs1 value or zero-extended zimm
//     csr_rdata      current value of csr_addr, from the read decoder
//     csr_illegal    write attempted to a read-only address
//     redirect_valid redirect PC offered to fetch
//     redirect_pc    redirect target
//     redirect_ready fetch accepts the redirect
//
//   Modports:
//     master  core / fetch side (drives requests, consumes redirect)
//     slave   CSR block side
// -----------------------------------------------------------------------------
interface csr_regs_if #(
  parameter int N = 64
) ();

  logic         csr_we;
  logic [1:0]   csr_op;
  logic [11:0]  csr_addr;
  logic [N-1:0] csr_wdata;
  logic [N-1:0] csr_rdata;
  logic         csr_illegal;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         redirect_ready;

  modport master (
    output csr_we,
    output csr_op,
    output csr_addr,
    output csr_wdata,
    output csr_rdata,
    output redirect_ready,
    input  csr_illegal,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  csr_we,
    input  csr_op,
    input  csr_addr,
    input  csr_wdata,
    input  csr_rdata,
    input  redirect_ready,
    output csr_illegal,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/csr_regs.sv
// -----------------------------------------------------------------------------
// csr_regs
//   Machine-mode CSR register file and trap sequencer.
//   Holds mscratch, mstatus, mcause, mtvec and mepc, executes CSRRW/CSRRS/CSRRC
//   writes, and sequences trap entry and mret by offering a redirect PC to
//   fetch over a valid/ready handshake.
//
//   Optional feature macro: CSR_COUNTERS_EN
//     defined   -> mcycle (index 5) and minstret (index 6) are live counters
//     undefined -> indices 5 and 6 read 0, writes to them are ignored
//
//   Ports:
//     clk           clock, rising edge
//     reset_n       asynchronous active-low reset
//     bus           csr_regs_if.slave (CSR write channel + redirect handshake)
//     exc_valid     synchronous exception/interrupt request
//     exc_cause     mcause value (bit N-1 set for interrupts)
//     exc_pc        PC of the faulting instruction
//     mret_valid    mret executing
//     instr_retire  one instruction retired (counters only)
//     csr_out       W_CSR x N register image for the read decoder
//     busy          sequencer is offering a redirect
// -----------------------------------------------------------------------------
module csr_regs #(
  parameter int N     = 64,
  parameter int W_CSR = 256
) (
  input  logic                      clk,
  input  logic                      reset_n,
  csr_regs_if.slave                 bus,
  input  logic                      exc_valid,
  input  logic [N-1:0]              exc_cause,
  input  logic [N-1:0]              exc_pc,
  input  logic                      mret_valid,
  input  logic                      instr_retire,
  output logic [W_CSR-1:0][N-1:0]   csr_out,
  output logic                      busy
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
`endif

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP_RDR = 2'd1,
    MRET_RDR = 2'd2
  } state_t;

  state_t state, state_next;

  // Architectural state. mstatus is kept as its two writable bits only.
  logic [N-1:0] mscratch;
  logic [N-1:0] mcause;
  logic [N-1:0] mtvec;
  logic [N-1:0] mepc;
  logic         mie;
  logic         mpie;

  logic         take_trap;
  logic         take_mret;
  logic         do_write;
  logic         read_only;
  logic [N-1:0] wval;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Read-modify-write result of a CSR instruction.
  function automatic logic [N-1:0] csr_alu(input logic [1:0]   op,
                                           input logic [N-1:0] old,
                                           input logic [N-1:0] wdata);
    logic [N-1:0] r;
    case (op)
      OP_RW:   r = wdata;
      OP_RS:   r = old | wdata;
      OP_RC:   r = old & ~wdata;
      default: r = old;
    endcase
    return r;
  endfunction

  // Instruction-aligned PCs and trap vectors have their low two bits cleared.
  function automatic logic [N-1:0] align4(input logic [N-1:0] v);
    return {v[N-1:2], 2'b00};
  endfunction

  // Full mstatus view: MPP hard-wired to M-mode, only MIE/MPIE live.
  function automatic logic [N-1:0] mstatus_pack(input logic ie, input logic pie);
    logic [N-1:0] v;
    v        = '0;
    v[3]     = ie;
    v[7]     = pie;
    v[12:11] = 2'b11;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign read_only       = (bus.csr_addr[11:10] == 2'b11);
  assign wval            = csr_alu(bus.csr_op, bus.csr_rdata, bus.csr_wdata);
  assign bus.csr_illegal = bus.csr_we && (bus.csr_op != 2'b00) && read_only;
  assign busy            = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next         = state;
    take_trap          = 1'b0;
    take_mret          = 1'b0;
    do_write           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state)
      IDLE: begin
        // Trap beats mret beats CSR write; a losing write is simply dropped.
        if (exc_valid) begin
          take_trap  = 1'b1;
          state_next = TRAP_RDR;
        end else if (mret_valid) begin
          take_mret  = 1'b1;
          state_next = MRET_RDR;
        end else if (bus.csr_we && (bus.csr_op != 2'b00) && !read_only) begin
          do_write = 1'b1;
        end
      end
      TRAP_RDR: begin
        // mtvec cannot change while busy, so the target is stable.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = align4(mtvec);
        if (bus.redirect_ready) state_next = IDLE;
      end
      MRET_RDR: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = mepc;
        if (bus.redirect_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mscratch <= '0;
      mcause   <= '0;
      mtvec    <= '0;
      mepc     <= '0;
      mie      <= 1'b0;
      mpie     <= 1'b0;
    end else if (take_trap) begin
      mepc   <= align4(exc_pc);
      mcause <= exc_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (take_mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (do_write) begin
      // misa and unmapped addresses fall through to the default and are ignored.
      case (bus.csr_addr)
        ADDR_MSCRATCH: mscratch <= wval;
        ADDR_MSTATUS: begin
          mie  <= wval[3];
          mpie <= wval[7];
        end
        ADDR_MCAUSE:   mcause <= wval;
        ADDR_MTVEC:    mtvec  <= align4(wval);
        ADDR_MEPC:     mepc   <= align4(wval);
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [N-1:0] mcycle;
  logic [N-1:0] minstret;
  logic         wr_mcycle;
  logic         wr_minstret;

  assign wr_mcycle   = do_write && (bus.csr_addr == ADDR_MCYCLE);
  assign wr_minstret = do_write && (bus.csr_addr == ADDR_MINSTRET);

  // ---------------------------------------------------------------------------
  // Counters: a CSR write wins over the increment; natural wrap at 2^N
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_mcycle) mcycle <= wval;
      else           mcycle <= mcycle + N'(1);
      if (wr_minstret) minstret <= wval;
      else             minstret <= minstret + N'(instr_retire);
    end
  end

  logic unused_bits;
  assign unused_bits = ^exc_pc[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{exc_pc[1:0], instr_retire};
`endif

  // ---------------------------------------------------------------------------
  // Register image for the read decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    csr_out    = '0;
    csr_out[0] = mscratch;
    csr_out[1] = mstatus_pack(mie, mpie);
    csr_out[2] = mcause;
    csr_out[3] = mtvec;
    csr_out[4] = mepc;
`ifdef CSR_COUNTERS_EN
    csr_out[5] = mcycle;
    csr_out[6] = minstret;
`endif
  end

endmodule

// File: tb/tb_csr_regs.sv
// -----------------------------------------------------------------------------
// tb_csr_regs
//   Self-checking bench for csr_regs. A behavioural model of the CSR file
//   (named registers, a pending-redirect flag) is stepped at each rising edge
//   from the same inputs; a compare process checks every DUT output against
//   it on each falling edge. Directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_csr_regs;

  localparam int N     = 64;
  localparam int W_CSR = 256;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    exc_valid;
  logic [N-1:0]            exc_cause;
  logic [N-1:0]            exc_pc;
  logic                    mret_valid;
  logic                    instr_retire;
  logic [W_CSR-1:0][N-1:0] csr_out;
  logic                    busy;

  csr_regs_if #(.N(N)) bus ();

  csr_regs #(.N(N), .W_CSR(W_CSR)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .exc_valid    (exc_valid),
    .exc_cause    (exc_cause),
    .exc_pc       (exc_pc),
    .mret_valid   (mret_valid),
    .instr_retire (instr_retire),
    .csr_out      (csr_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [N-1:0] m_scratch, m_cause, m_tvec, m_epc, m_cycle, m_instret;
  bit           m_mie, m_mpie;
  int           m_pend;   // 0: no redirect, 1: trap redirect, 2: mret redirect

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] m_status();
    return 64'h1800 + (m_mie ? 64'd8 : 64'd0) + (m_mpie ? 64'd128 : 64'd0);
  endfunction

  function automatic logic [N-1:0] m_idx(input int i);
    case (i)
      0: return m_scratch;
      1: return m_status();
      2: return m_cause;
      3: return m_tvec;
      4: return m_epc;
      5: return m_cycle;
      6: return m_instret;
      default: return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] m_addr_val(input logic [11:0] a);
    case (a)
      12'h340: return m_scratch;
      12'h300: return m_status();
      12'h342: return m_cause;
      12'h305: return m_tvec;
      12'h341: return m_epc;
      12'hB00: return m_cycle;
      12'hB02: return m_instret;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_scratch = '0; m_cause = '0; m_tvec = '0; m_epc = '0;
    m_cycle = '0; m_instret = '0; m_mie = 0; m_mpie = 0; m_pend = 0;
  endtask

  // One clock edge of architectural behaviour, using the pre-edge inputs.
  task automatic model_step();
    logic [N-1:0] nv, cyc_n, ins_n;
    if (!reset_n) begin
      model_reset();
      return;
    end
    cyc_n = m_cycle + 1;
    ins_n = m_instret + (instr_retire ? 64'd1 : 64'd0);
    if (m_pend == 0) begin
      if (exc_valid) begin
        m_epc  = exc_pc & ~64'h3;
        m_cause = exc_cause;
        m_mpie = m_mie;
        m_mie  = 0;
        m_pend = 1;
      end else if (mret_valid) begin
        m_mie  = m_mpie;
        m_mpie = 1;
        m_pend = 2;
      end else if (bus.csr_we && bus.csr_op != 0 && (bus.csr_addr >> 10) != 3) begin
        if (bus.csr_op == 1)      nv = bus.csr_wdata;
        else if (bus.csr_op == 2) nv = bus.csr_rdata | bus.csr_wdata;
        else                      nv = bus.csr_rdata & ~bus.csr_wdata;
        case (bus.csr_addr)
          12'h340: m_scratch = nv;
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h342: m_cause = nv;
          12'h305: m_tvec = nv & ~64'h3;
          12'h341: m_epc  = nv & ~64'h3;
          12'hB00: cyc_n = nv;
          12'hB02: ins_n = nv;
          default: ;
        endcase
      end
    end else if (bus.redirect_ready) begin
      m_pend = 0;
    end
    if (CNT) begin
      m_cycle   = cyc_n;
      m_instret = ins_n;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_pc;
    for (int i = 0; i < 7; i++) check($sformatf("csr_out[%0d]", i), csr_out[i], m_idx(i));
    check("csr_out[7]", csr_out[7], '0);
    check("csr_out[255]", csr_out[W_CSR-1], '0);
    exp_pc = (m_pend == 1) ? m_tvec : (m_pend == 2) ? m_epc : '0;
    check("redirect_valid", bus.redirect_valid, (m_pend != 0));
    check("redirect_pc", bus.redirect_pc, exp_pc);
    check("busy", busy, (m_pend != 0));
    check("csr_illegal", bus.csr_illegal,
          (bus.csr_we && bus.csr_op != 0 && bus.csr_addr[11:10] == 2'b11));
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    bus.csr_rdata = m_addr_val(bus.csr_addr);
  endtask

  task automatic csr_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [N-1:0] wd);
    bus.csr_we    = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = addr;
    bus.csr_wdata = wd;
    bus.csr_rdata = m_addr_val(addr);
    tick();
    bus.csr_we = 1'b0;
    bus.csr_op = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    exc_valid = 0; exc_cause = '0; exc_pc = '0; mret_valid = 0; instr_retire = 0;
    bus.csr_we = 0; bus.csr_op = 0; bus.csr_addr = '0; bus.csr_wdata = '0;
    bus.csr_rdata = '0; bus.redirect_ready = 0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    check("lit_reset_mstatus", csr_out[1], 64'h1800);
    check("lit_reset_busy", busy, 1'b0);

    // Basic write and read-modify-write on mstatus
    csr_cmd(2'b01, 12'h340, 64'hDEAD_BEEF);
    check("lit_mscratch", csr_out[0], 64'hDEAD_BEEF);
    check("lit_model_mscratch", m_scratch, 64'hDEAD_BEEF);
    csr_cmd(2'b01, 12'h300, 64'h8);
    check("lit_mstatus_1808", csr_out[1], 64'h1808);
    csr_cmd(2'b11, 12'h300, 64'h8);
    check("lit_mstatus_rc", csr_out[1], 64'h1800);
    csr_cmd(2'b10, 12'h300, 64'hFFFF);
    check("lit_mstatus_rs", csr_out[1], 64'h1888);
    check("lit_model_mstatus", m_status(), 64'h1888);

    // Masking, ignored addresses
    csr_cmd(2'b01, 12'h341, 64'h12347);
    check("lit_mepc_mask", csr_out[4], 64'h12344);
    csr_cmd(2'b01, 12'h301, 64'hFFFF);
    csr_cmd(2'b01, 12'h7C0, 64'h1234);
    csr_cmd(2'b01, 12'hB00, 64'h5);
    csr_cmd(2'b01, 12'h305, 64'h8000_0001);
    check("lit_mtvec", csr_out[3], 64'h8000_0000);
    csr_cmd(2'b01, 12'h300, 64'h8);

    // Trap entry with a stalled redirect
    exc_valid = 1; exc_cause = 64'd2; exc_pc = 64'h1006;
    tick();
    exc_valid = 0;
    check("lit_trap_mepc", csr_out[4], 64'h1004);
    check("lit_trap_mcause", csr_out[2], 64'd2);
    check("lit_trap_mstatus", csr_out[1], 64'h1880);
    check("lit_trap_valid", bus.redirect_valid, 1'b1);
    repeat (3) tick();
    check("lit_trap_pc_held", bus.redirect_pc, 64'h8000_0000);
    check("lit_trap_valid_held", bus.redirect_valid, 1'b1);
    bus.redirect_ready = 1;
    tick();
    bus.redirect_ready = 0;
    check("lit_trap_done", bus.redirect_valid, 1'b0);

    // Simultaneous trap, mret and write: only the trap happens
    exc_valid = 1; exc_cause = 64'h8000_0000_0000_0007; exc_pc = 64'h2000;
    mret_valid = 1;
    bus.csr_we = 1; bus.csr_op = 2'b01; bus.csr_addr = 12'h340; bus.csr_wdata = 64'h1111;
    bus.csr_rdata = m_addr_val(12'h340);
    tick();
    check("lit_simul_busy", busy, 1'b1);
    check("lit_simul_mcause", csr_out[2], 64'h8000_0000_0000_0007);
    exc_cause = 64'd5; exc_pc = 64'h3000;
    repeat (2) tick();
    check("lit_simul_mscratch", csr_out[0], 64'hDEAD_BEEF);
    check("lit_simul_mepc", csr_out[4], 64'h2000);
    exc_valid = 0; mret_valid = 0; bus.csr_we = 0; bus.csr_op = 0;
    bus.redirect_ready = 1;
    tick();
    bus.redirect_ready = 0;

    // Read-only region
    bus.csr_we = 1; bus.csr_op = 2'b01; bus.csr_addr = 12'hF14; bus.csr_wdata = 64'h55;
    #1;
    check("lit_illegal", bus.csr_illegal, 1'b1);
    tick();
    bus.csr_op = 2'b00;
    #1;
    check("lit_illegal_noop", bus.csr_illegal, 1'b0);
    bus.csr_we = 0;

    // mret, then reset in the middle of the redirect
    mret_valid = 1;
    tick();
    mret_valid = 0;
    check("lit_mret_pc", bus.redirect_pc, 64'h2000);
    check("lit_mret_mstatus", csr_out[1], 64'h1880);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("lit_rst_valid", bus.redirect_valid, 1'b0);
    check("lit_rst_busy", busy, 1'b0);
    check("lit_rst_mscratch", csr_out[0], 64'h0);
    tick();
    reset_n = 1'b1;
    check("lit_rst_mstatus", csr_out[1], 64'h1800);

`ifdef CSR_COUNTERS_EN
    csr_cmd(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    check("lit_mcycle_max", csr_out[5], 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("lit_mcycle_wrap", csr_out[5], 64'h0);
    instr_retire = 1;
    csr_cmd(2'b01, 12'hB02, 64'd5);
    check("lit_minstret_write", csr_out[6], 64'd5);
    tick();
    instr_retire = 0;
    check("lit_minstret_inc", csr_out[6], 64'd6);
`else
    instr_retire = 1;
    csr_cmd(2'b01, 12'hB02, 64'd5);
    instr_retire = 0;
    check("lit_minstret_off", csr_out[6], 64'd0);
`endif

    repeat (2) tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
